// File: rtl/io_bus_master.sv
// io_bus_master: single-word load/store initiator for the memory-mapped I/O bus,
// with a rising-edge interrupt detector feeding an explicitly cleared pending flag.
module io_bus_master #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned BEW         = 4,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [0:AW-1]  cpu_addr,
  input  logic [0:BEW-1] cpu_be,
  input  logic [0:DW-1]  cpu_wdata,
  output logic           cpu_ack,
  output logic [0:DW-1]  cpu_rdata,
  output logic           cpu_busy,
  output logic [0:AW-1]  io_addr,
  output logic           io_wr,
  output logic [0:BEW-1] io_be,
  output logic [0:DW-1]  io_din,
  input  logic [0:DW-1]  io_dout,
  input  logic           io_hw_int,
  input  logic           int_ack,
  output logic           int_pend
);

  localparam int unsigned      CNT_W     = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_capture;

  logic             r_we;
  logic             r_cpu_ack;
  logic             r_cpu_busy;
  logic [0:DW-1]    r_cpu_rdata;
  logic [0:AW-1]    r_io_addr;
  logic             r_io_wr;
  logic [0:BEW-1]   r_io_be;
  logic [0:DW-1]    r_io_din;

  logic             r_int_q;
  logic             r_int_pend;
  logic             w_int_rise;

  // Next-state, settle counter and read-capture decision.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_accept     = 1'b1;
          w_next_state = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_we) begin
          w_next_state = S_DONE;
        end else if (WAIT_INIT == '0) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_cnt_next   = WAIT_INIT;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_capture    = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Bus-side registers: request fields stay on the bus until the next accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_busy  <= 1'b0;
      r_cpu_rdata <= '0;
      r_io_addr   <= '0;
      r_io_wr     <= 1'b0;
      r_io_be     <= '0;
      r_io_din    <= '0;
    end else begin
      r_cpu_ack  <= (w_next_state == S_DONE);
      r_cpu_busy <= (w_next_state != S_IDLE);
      r_io_wr    <= w_accept & cpu_we;
      if (w_accept) begin
        r_we      <= cpu_we;
        r_io_addr <= cpu_addr;
        r_io_be   <= cpu_be;
        r_io_din  <= cpu_wdata;
      end
      if (w_capture) begin
        r_cpu_rdata <= io_dout;
      end
    end
  end

  assign w_int_rise = io_hw_int & ~r_int_q;

  // Pending flag: a fresh rising edge beats a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int_q    <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_int_q <= io_hw_int;
      if (w_int_rise) begin
        r_int_pend <= 1'b1;
      end else if (int_ack) begin
        r_int_pend <= 1'b0;
      end
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_busy  = r_cpu_busy;
  assign cpu_rdata = r_cpu_rdata;
  assign io_addr   = r_io_addr;
  assign io_wr     = r_io_wr;
  assign io_be     = r_io_be;
  assign io_din    = r_io_din;
  assign int_pend  = r_int_pend;

endmodule

// File: doc/io_bus_master.md
# io_bus_master

Bus initiator for the memory-mapped I/O unit: accepts single-word load/store requests from the CPU data-memory stage over a request/acknowledge handshake. It drives the I/O bus address, write strobe, byte enables and write data. It captures read data after a programmable number of wait cycles. It also turns the I/O unit's level-style hardware interrupt into a pending flag that the CPU clears explicitly.

## Interface
- `AW`, 32: address width; all buses use big-endian bit numbering `[0:AW-1]`, bit 0 is the MSB.
- `DW`, 32: data width.
- `BEW`, 4: byte-enable width; bit 0 enables byte `[0:7]`.
- `WAIT_CYCLES`, 1: read settle cycles between address drive and data capture; legal range 0–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  request; sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  AW  request address.
- `cpu_be`  in  BEW  byte enables.
- `cpu_wdata`  in  DW  store data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  load data; valid while `cpu_ack`=1, held until the next load capture.
- `cpu_busy`  out  1  1 in any state other than IDLE.
- `io_addr`  out  AW  I/O bus address.
- `io_wr`  out  1  I/O write strobe.
- `io_be`  out  BEW  I/O byte enables.
- `io_din`  out  DW  write data to the I/O unit.
- `io_dout`  in  DW  read data from the I/O unit; combinational from `io_addr`.
- `io_hw_int`  in  1  interrupt level from the I/O unit.
- `int_ack`  in  1  clears the pending interrupt.
- `int_pend`  out  1  pending-interrupt flag.

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE:
  - If `cpu_req`=1, latch `cpu_we`, `cpu_addr`, `cpu_be` and `cpu_wdata` into internal registers, then go to SETUP.
  - CPU inputs are ignored in every other state.
- SETUP:
  - `io_addr`, `io_be` and `io_din` present the latched values.
  - Store: `io_wr`=1 for this cycle only, then go to DONE.
  - Load with `WAIT_CYCLES`=0: capture `io_dout` into `cpu_rdata` at the end of this cycle, then go to DONE.
  - Load with `WAIT_CYCLES`>0: load the 4-bit wait counter with `WAIT_CYCLES`, then go to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1, capture `io_dout` into `cpu_rdata` and go to DONE.
- DONE: `cpu_ack`=1 for exactly one cycle, then go to IDLE. A store leaves `cpu_rdata` unchanged.
- `io_addr`, `io_be` and `io_din` hold their latched values from SETUP until the next accepted request, including through IDLE. `io_wr` is 0 outside the SETUP cycle of a store.
- Interrupt path:
  - `int_q` registers `io_hw_int` every cycle.
  - A rising edge is `io_hw_int & ~int_q`.
  - A rising edge sets `int_pend`; `int_ack`=1 clears it.
  - If an edge and `int_ack` occur in the same cycle, set wins.
  - A level held high does not re-set the flag after it is acknowledged.
- The interrupt path is independent of the FSM; a pending interrupt does not abort a transfer.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - FSM returns to IDLE.
  - `cpu_ack`, `cpu_busy`, `io_wr` and `int_pend` = 0.
  - `cpu_rdata`, `io_addr`, `io_be`, `io_din` = 0; `int_q` = 0.
- Reset mid-transfer: no `cpu_ack` is issued. A store whose SETUP cycle already occurred stays committed.
- Request accepted at edge T0, so SETUP is cycle T0+1.
  - Store: `io_wr`=1 in T0+1; `cpu_ack` in T0+2.
  - Load: `cpu_ack` in T0+2+`WAIT_CYCLES`.
- Back-to-back: a `cpu_req` held high through DONE is accepted on the first IDLE cycle. The minimum request spacing is 3 cycles for stores.
- `cpu_busy` rises in SETUP and falls in IDLE; it is 1 during DONE.
- `int_pend` rises one cycle after the first cycle in which `io_hw_int` is sampled high (unacknowledged). It falls the cycle after `int_ack`.

## Test plan
- Reset, then store `cpu_addr`=0x0000_7F10, `cpu_be`=0xF, `cpu_wdata`=0x0000_00A5 -> `io_wr`=1 for exactly one cycle at T0+1 with `io_addr`=0x0000_7F10 and `io_din`=0x0000_00A5; `cpu_ack` at T0+2; `cpu_rdata` stays 0.
- `WAIT_CYCLES`=1, load from 0x0000_7F00; `io_dout` changes 0x1111_1111 -> 0x2222_2222 at the start of WAIT -> `cpu_rdata`=0x2222_2222 with `cpu_ack` at T0+3.
- `WAIT_CYCLES`=0, load with `io_dout`=0xFFFF_FFFF (unmapped address) -> `cpu_ack` at T0+2, `cpu_rdata`=0xFFFF_FFFF.
- `cpu_req` held high for 3 back-to-back stores -> three `io_wr` pulses 3 cycles apart, three `cpu_ack` pulses; a `cpu_req` change during SETUP/DONE has no effect.
- `io_hw_int` held high for 10 cycles, `int_ack` pulsed at cycle 4 -> `int_pend` high cycles 1–4, low afterwards. A second rising edge coinciding with an `int_ack` pulse -> `int_pend` remains 1.
- Assert `rst_n`=0 during WAIT of a load -> next cycle IDLE, `cpu_busy`=0, no `cpu_ack`, `cpu_rdata`=0, `io_addr`=0.
